// File: rtl/uart_frame_loader_if.sv
// Byte-in / write-out bundle between the UART receiver, the frame loader and the SoC write mux.
`timescale 1ns/1ps
interface uart_frame_loader_if #(
  parameter int unsigned WIDTH_A = 32,
  parameter int unsigned WIDTH_D = 32
);
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               wr_en;
  logic [WIDTH_A-1:0] wr_addr;
  logic [WIDTH_D-1:0] wr_data;
  logic               busy;
  logic               err_end;
  logic               err_sum;
  logic               err_timeout;

  // Byte source / write sink side (host model, SoC glue)
  modport master (
    output rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data, busy, err_end, err_sum, err_timeout
  );

  // Frame decoder side
  modport slave (
    input  rx_valid, rx_data,
    output wr_en, wr_addr, wr_data, busy, err_end, err_sum, err_timeout
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Decodes single (0xAA) and checksummed burst (0xAB) loader frames from a UART byte
// stream into one-cycle write strobes, with an inter-byte timeout for resync.
`timescale 1ns/1ps
module uart_frame_loader #(
  parameter int unsigned WIDTH_A       = 32,
  parameter int unsigned WIDTH_D       = 32,
  parameter int unsigned TIMEOUT       = 50000,
  parameter int unsigned COUNTER_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_frame_loader_if.slave   bus
);

  localparam int unsigned ABYTES = WIDTH_A / 8;
  localparam int unsigned DBYTES = WIDTH_D / 8;
  localparam int unsigned MAXB   = (ABYTES > DBYTES) ? ABYTES : DBYTES;
  localparam int unsigned BCNT_W = $clog2(MAXB + 1);

  localparam logic [7:0] START_SINGLE = 8'hAA;
  localparam logic [7:0] START_BURST  = 8'hAB;
  localparam logic [7:0] END_BYTE     = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_SUM,
    S_END
  } state_t;

  state_t                   state, state_d;
  logic [BCNT_W-1:0]        bcnt, bcnt_d;
  logic [7:0]               wcnt, wcnt_d;
  logic [WIDTH_A-1:0]       addr_q, addr_d;
  logic [WIDTH_D-1:0]       data_q, data_d;
  logic [7:0]               sum_q, sum_d;
  logic                     burst_q, burst_d;
  logic [COUNTER_WIDTH-1:0] tcnt, tcnt_d;

  logic                     wr_en_q, wr_en_d;
  logic [WIDTH_A-1:0]       wr_addr_q, wr_addr_d;
  logic [WIDTH_D-1:0]       wr_data_q, wr_data_d;
  logic                     busy_q, busy_d;
  logic                     err_end_q, err_end_d;
  logic                     err_sum_q, err_sum_d;
  logic                     err_timeout_q, err_timeout_d;

  logic [WIDTH_A-1:0]       addr_shift;
  logic [WIDTH_D-1:0]       data_shift;

  // Fields arrive LSB first: each new byte enters at the top and earlier bytes move down
  assign addr_shift = (addr_q >> 8) | (WIDTH_A'(bus.rx_data) << (WIDTH_A - 8));
  assign data_shift = (data_q >> 8) | (WIDTH_D'(bus.rx_data) << (WIDTH_D - 8));

  // Next-state, datapath and registered-output next values
  always_comb begin
    state_d       = state;
    bcnt_d        = bcnt;
    wcnt_d        = wcnt;
    addr_d        = addr_q;
    data_d        = data_q;
    sum_d         = sum_q;
    burst_d       = burst_q;
    tcnt_d        = tcnt;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    err_end_d     = 1'b0;
    err_sum_d     = 1'b0;
    err_timeout_d = 1'b0;

    if (state == S_IDLE || bus.rx_valid) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt + COUNTER_WIDTH'(1);
    end

    if (bus.rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (bus.rx_data == START_SINGLE || bus.rx_data == START_BURST) begin
            state_d = S_ADDR;
            burst_d = (bus.rx_data == START_BURST);
            bcnt_d  = '0;
            sum_d   = '0;
          end
        end
        S_ADDR: begin
          addr_d = addr_shift;
          sum_d  = sum_q + bus.rx_data;
          if (bcnt == BCNT_W'(ABYTES - 1)) begin
            bcnt_d  = '0;
            state_d = burst_q ? S_COUNT : S_DATA;
          end else begin
            bcnt_d = bcnt + BCNT_W'(1);
          end
        end
        S_COUNT: begin
          wcnt_d  = bus.rx_data;
          sum_d   = sum_q + bus.rx_data;
          bcnt_d  = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          data_d = data_shift;
          sum_d  = sum_q + bus.rx_data;
          if (bcnt == BCNT_W'(DBYTES - 1)) begin
            bcnt_d = '0;
            if (burst_q) begin
              // Count 0 wraps to 255 on the first word, so 0 encodes 256 words
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = data_shift;
              addr_d    = addr_q + WIDTH_A'(1);
              wcnt_d    = wcnt - 8'd1;
              if (wcnt == 8'd1) begin
                state_d = S_SUM;
              end
            end else begin
              state_d = S_END;
            end
          end else begin
            bcnt_d = bcnt + BCNT_W'(1);
          end
        end
        S_SUM: begin
          err_sum_d = (bus.rx_data != sum_q);
          state_d   = S_END;
        end
        S_END: begin
          if (bus.rx_data == END_BYTE) begin
            if (!burst_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = data_q;
            end
          end else begin
            err_end_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state != S_IDLE && tcnt == COUNTER_WIDTH'(TIMEOUT - 1)) begin
      state_d       = S_IDLE;
      err_timeout_d = 1'b1;
      tcnt_d        = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      bcnt          <= '0;
      wcnt          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      sum_q         <= '0;
      burst_q       <= 1'b0;
      tcnt          <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      err_end_q     <= 1'b0;
      err_sum_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state         <= state_d;
      bcnt          <= bcnt_d;
      wcnt          <= wcnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      sum_q         <= sum_d;
      burst_q       <= burst_d;
      tcnt          <= tcnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      err_end_q     <= err_end_d;
      err_sum_q     <= err_sum_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = busy_q;
  assign bus.err_end     = err_end_q;
  assign bus.err_sum     = err_sum_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench: a frame-level byte-queue model predicts every output each cycle;
// hand-computed write/error logs pin the model per directed scenario.
`timescale 1ns/1ps
module tb_uart_frame_loader;

  localparam int unsigned WA = 32;
  localparam int unsigned WD = 32;
  localparam int unsigned TO = 20;
  localparam int unsigned CW = 8;
  localparam int         AB = 4;
  localparam int         DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_frame_loader_if #(.WIDTH_A(WA), .WIDTH_D(WD)) bus ();

  uart_frame_loader #(
    .WIDTH_A(WA), .WIDTH_D(WD), .TIMEOUT(TO), .COUNTER_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit          m_open, m_burst;
  logic [7:0]  m_q[$];
  int          m_idle;
  logic [31:0] e_addr, e_data;
  bit          e_wr, e_end, e_sum, e_to;

  function automatic logic [31:0] field(input int start, input int nb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r = r | (32'(m_q[start + i]) << (8 * i));
    return r;
  endfunction

  task automatic model_reset();
    m_open = 0; m_burst = 0; m_q.delete(); m_idle = 0;
    e_addr = '0; e_data = '0;
    e_wr = 0; e_end = 0; e_sum = 0; e_to = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int n, hdr, nw, body, k;
    logic [7:0] s;
    e_wr = 0; e_end = 0; e_sum = 0; e_to = 0;
    if (!v) begin
      if (m_open) begin
        m_idle++;
        if (m_idle >= int'(TO)) begin m_open = 0; e_to = 1; end
      end
    end else begin
      m_idle = 0;
      if (!m_open) begin
        if (d == 8'hAA || d == 8'hAB) begin
          m_open = 1; m_burst = (d == 8'hAB);
          m_q.delete(); m_q.push_back(d);
        end
      end else begin
        m_q.push_back(d);
        n = m_q.size();
        if (!m_burst) begin
          if (n == 2 + AB + DB) begin
            m_open = 0;
            if (d == 8'h55) begin
              e_wr = 1; e_addr = field(1, AB); e_data = field(1 + AB, DB);
            end else e_end = 1;
          end
        end else begin
          hdr = 2 + AB;
          if (n > hdr) begin
            nw   = (m_q[1 + AB] == 8'd0) ? 256 : int'(m_q[1 + AB]);
            body = n - hdr;
            if (body <= nw * DB && body % DB == 0) begin
              k = body / DB - 1;
              e_wr = 1;
              e_addr = field(1, AB) + 32'(k);
              e_data = field(hdr + k * DB, DB);
            end else if (body == nw * DB + 1) begin
              s = '0;
              for (int i = 1; i <= n - 2; i++) s = s + m_q[i];
              e_sum = (d != s);
            end else if (body == nw * DB + 2) begin
              m_open = 0;
              e_end = (d != 8'h55);
            end
          end
        end
      end
    end
  endtask

  // ---------------- observed event log ----------------
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int n_end, n_sum, n_to, to_cyc, last_byte_cyc;

  // Per-cycle comparison against the model
  initial begin : compare
    logic       v;
    logic [7:0] d;
    model_reset();
    forever begin
      @(posedge clk);
      v = bus.rx_valid;
      d = bus.rx_data;
      @(negedge clk);
      if (!reset) begin
        model_reset();
      end else begin
        model_step(v, d);
      end
      chk("wr_en",       32'(bus.wr_en),       32'(e_wr));
      chk("wr_addr",     bus.wr_addr,          e_addr);
      chk("wr_data",     bus.wr_data,          e_data);
      chk("err_end",     32'(bus.err_end),     32'(e_end));
      chk("err_sum",     32'(bus.err_sum),     32'(e_sum));
      chk("err_timeout", 32'(bus.err_timeout), 32'(e_to));
      chk("busy",        32'(bus.busy),        32'(m_open));
      if (bus.wr_en) begin log_addr.push_back(bus.wr_addr); log_data.push_back(bus.wr_data); end
      if (bus.err_end) n_end++;
      if (bus.err_sum) n_sum++;
      if (bus.err_timeout) begin n_to++; to_cyc = cyc; end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] seq[$];

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    last_byte_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_seq(input int gap);
    foreach (seq[i]) begin
      if (i > 0) idle(gap);
      send_byte(seq[i]);
    end
    seq.delete();
  endtask

  task automatic push_bytes(input logic [31:0] w);
    for (int i = 0; i < 4; i++) seq.push_back(8'(w >> (8 * i)));
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete();
    n_end = 0; n_sum = 0; n_to = 0;
  endtask

  task automatic expect_log(input string name, input int nwr, input int ne, input int ns, input int nt);
    idle(3);
    chk({name, "_writes"}, 32'(log_addr.size()), 32'(nwr));
    chk({name, "_err_end"}, 32'(n_end), 32'(ne));
    chk({name, "_err_sum"}, 32'(n_sum), 32'(ns));
    chk({name, "_err_to"},  32'(n_to),  32'(nt));
  endtask

  task automatic expect_wr(input string name, input int idx, input logic [31:0] a, input logic [31:0] dv);
    logic [31:0] aa, dd;
    aa = (idx < log_addr.size()) ? log_addr[idx] : 32'hXXXX_XXXX;
    dd = (idx < log_data.size()) ? log_data[idx] : 32'hXXXX_XXXX;
    chk({name, "_addr"}, aa, a);
    chk({name, "_data"}, dd, dv);
  endtask

  initial begin : main
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", bus.wr_addr, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;

    // Single frame
    clear_log();
    seq = '{8'hAA, 8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h55};
    send_seq(0);
    expect_log("single", 1, 0, 0, 0);
    expect_wr("single", 0, 32'h0000_4000, 32'h0000_0001);

    // Bad end byte, then a good frame
    clear_log();
    seq = '{8'hAA, 8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h54};
    send_seq(0);
    expect_log("bad_end", 0, 1, 0, 0);
    chk("bad_end_busy", 32'(bus.busy), 32'd0);
    clear_log();
    seq = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h55};
    send_seq(0);
    expect_log("after_bad", 1, 0, 0, 0);
    expect_wr("after_bad", 0, 32'h7856_3412, 32'hDEAD_BEEF);

    // Burst of three, checksum 0xAB
    clear_log();
    seq = '{8'hAB, 8'h10, 8'h00, 8'h00, 8'h00, 8'h03};
    push_bytes(32'h1111_1111); push_bytes(32'h2222_2222); push_bytes(32'h3333_3333);
    seq.push_back(8'hAB); seq.push_back(8'h55);
    send_seq(0);
    expect_log("burst", 3, 0, 0, 0);
    expect_wr("burst0", 0, 32'h10, 32'h1111_1111);
    expect_wr("burst1", 1, 32'h11, 32'h2222_2222);
    expect_wr("burst2", 2, 32'h12, 32'h3333_3333);

    // Same burst, checksum off by one
    clear_log();
    seq = '{8'hAB, 8'h10, 8'h00, 8'h00, 8'h00, 8'h03};
    push_bytes(32'h1111_1111); push_bytes(32'h2222_2222); push_bytes(32'h3333_3333);
    seq.push_back(8'hAC); seq.push_back(8'h55);
    send_seq(0);
    expect_log("badsum", 3, 0, 1, 0);

    // Address wrap, checksum 0x40
    clear_log();
    seq = '{8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02};
    push_bytes(32'hDEAD_BEEF); push_bytes(32'h0102_0304);
    seq.push_back(8'h40); seq.push_back(8'h55);
    send_seq(0);
    expect_log("wrap", 2, 0, 0, 0);
    expect_wr("wrap0", 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    expect_wr("wrap1", 1, 32'h0000_0000, 32'h0102_0304);

    // Stall after three bytes
    clear_log();
    seq = '{8'hAA, 8'h01, 8'h02};
    send_seq(0);
    idle(2 * int'(TO));
    expect_log("stall", 0, 0, 0, 1);
    chk("stall_latency", 32'(to_cyc - last_byte_cyc), 32'(TO));
    chk("stall_busy", 32'(bus.busy), 32'd0);

    // Bytes spaced TIMEOUT-1 cycles apart
    clear_log();
    seq = '{8'hAA, 8'h04, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h55};
    send_seq(int'(TO) - 2);
    expect_log("space_tm1", 1, 0, 0, 0);
    expect_wr("space_tm1", 0, 32'h4, 32'h5);

    // Bytes spaced exactly TIMEOUT apart: the byte wins over the expiring counter
    clear_log();
    seq = '{8'hAA, 8'h06, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h55};
    send_seq(int'(TO) - 1);
    expect_log("space_t", 1, 0, 0, 0);
    expect_wr("space_t", 0, 32'h6, 32'h7);

    // Back-to-back frames, no gap
    clear_log();
    seq = '{8'hAA, 8'h20, 8'h00, 8'h00, 8'h00, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h55,
            8'hAA, 8'h21, 8'h00, 8'h00, 8'h00, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h55};
    send_seq(0);
    expect_log("b2b", 2, 0, 0, 0);
    expect_wr("b2b0", 0, 32'h20, 32'hA1);
    expect_wr("b2b1", 1, 32'h21, 32'hA2);

    // Reset during DATA
    clear_log();
    seq = '{8'hAA, 8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    send_seq(0);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_wr_addr", bus.wr_addr, 32'd0);
    chk("midrst_wr_data", bus.wr_data, 32'd0);
    idle(2);
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    seq = '{8'h33, 8'h44, 8'h55};
    send_seq(0);
    expect_log("midrst", 0, 0, 0, 0);
    clear_log();
    seq = '{8'hAA, 8'h09, 8'h00, 8'h00, 8'h00, 8'h99, 8'h00, 8'h00, 8'h00, 8'h55};
    send_seq(0);
    expect_log("post_rst", 1, 0, 0, 0);
    expect_wr("post_rst", 0, 32'h9, 32'h99);

    // Idle garbage is ignored
    clear_log();
    seq = '{8'h00, 8'h55, 8'h12};
    send_seq(0);
    expect_log("garbage", 0, 0, 0, 0);

    // Count byte 0 means 256 words; data byte i per word, checksum 0x81
    clear_log();
    seq = '{8'hAB, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) push_bytes(32'(i));
    seq.push_back(8'h81); seq.push_back(8'h55);
    send_seq(0);
    expect_log("n256", 256, 0, 0, 0);
    expect_wr("n256_first", 0, 32'h100, 32'h0);
    expect_wr("n256_last", 255, 32'h1FF, 32'hFF);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Byte-stream frame decoder that turns host UART traffic into memory/control-register writes for the SoC loader path. It generalises the existing single-word loader protocol (0xAA, address, data, 0x55) to parametrised address and data widths. It adds a checksummed burst mode with auto-incrementing address and an inter-byte timeout for resynchronisation. It sits between the UART receiver (byte valid/data) and the SoC write mux that feeds instruction memory, data memory and the 0x5000 control registers.

## Interface
- WIDTH_A, 32, address width in bits; multiple of 8; ABYTES = WIDTH_A/8
- WIDTH_D, 32, data width in bits; multiple of 8; DBYTES = WIDTH_D/8
- TIMEOUT, 50000, idle clk cycles without a byte before an open frame is aborted; ≥ 2
- COUNTER_WIDTH, 16, width of the timeout counter; 2^COUNTER_WIDTH > TIMEOUT
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  WIDTH_A  write address, valid while wr_en
- wr_data  out  WIDTH_D  write data, valid while wr_en
- busy  out  1  high whenever the FSM is not in IDLE
- err_end  out  1  one-cycle pulse: bad end byte
- err_sum  out  1  one-cycle pulse: burst checksum mismatch
- err_timeout  out  1  one-cycle pulse: frame aborted by timeout

## Operation
- Single frame: 0xAA, ABYTES address bytes (LSB first), DBYTES data bytes (LSB first), 0x55. The write is issued only if the end byte is 0x55. Otherwise err_end pulses and no write occurs.
- Burst frame: 0xAB, ABYTES address bytes, count byte N (1..255; 0 means 256), N×DBYTES data bytes, checksum byte, 0x55.
- In a burst, a write is issued as each word completes. The address starts at the received address and increments by 1 per word, modulo 2^WIDTH_A.
- Checksum = 8-bit sum (mod 256) of all address, count and data bytes.
- Burst checksum mismatch → err_sum pulses when the checksum byte arrives. The FSM still expects the end byte.
- Burst bad end byte → err_end pulses. Writes already issued in a burst are not retracted.
- FSM states: IDLE → (0xAA|0xAB) ADDR → DATA (single) or COUNT → DATA (burst) → SUM (burst only) → END → IDLE.
- In IDLE, bytes other than 0xAA/0xAB are ignored, with no error.
- Byte counters run within each field. The word counter counts down N. The shift register assembles each word LSB first.
- Timeout: the counter clears on every rx_valid and increments each cycle while busy. When it reaches TIMEOUT, the FSM returns to IDLE and err_timeout pulses. The counter is held at 0 in IDLE.
- rx_valid in the same cycle the counter would reach TIMEOUT: the byte wins, the counter clears and there is no timeout.
- No back-pressure: every byte presented is consumed. The downstream write path must accept one write per cycle.

## Timing
- Reset (asynchronous assert): state IDLE; all outputs 0 (wr_en, wr_addr, wr_data, busy, err_*). Counters and checksum are 0.
- Reset asserted mid-frame: the frame is discarded and no write or error is issued. After release, only a fresh start byte is decoded.
- All outputs are registered.
- wr_en, wr_addr and wr_data appear the cycle after the rx_valid that carries the end byte (single frame) or the last byte of a word (burst). Latency is 1 clk.
- err_end and err_sum assert the cycle after the offending byte's rx_valid. err_timeout asserts the cycle after the counter reaches TIMEOUT.
- busy rises the cycle after the start byte and falls the cycle after the end byte or timeout.
- wr_addr and wr_data hold their last values when wr_en is low.
- Back-to-back frames: a start byte on the first rx_valid after END is accepted, with no gap cycle required.

## Test plan
- Single frame AA 00 40 00 00 01 00 00 00 55 → one wr_en, wr_addr=0x00004000, wr_data=0x00000001; no errors.
- Single frame with end byte 0x54 → err_end pulse, no wr_en, busy falls; the next valid frame writes normally.
- Burst AB 10 00 00 00 03 + words 0x11111111, 0x22222222, 0x33333333 + correct checksum + 55 → three wr_en at 0x10, 0x11, 0x12 with those data values; no errors.
- Same burst with checksum off by one → three writes, err_sum pulse, no err_end.
- Burst at address 0xFFFFFFFF, N=2 → writes at 0xFFFFFFFF then 0x00000000.
- Stall after 3 bytes of a frame → err_timeout exactly TIMEOUT cycles after the last byte, busy=0.
- Bytes spaced exactly TIMEOUT−1 cycles apart → no timeout.
- reset low during DATA → all outputs 0 immediately, no write after release.
